// File: rtl/demux_pkg.sv
// demux_pkg: shared defaults and lane index type for the registered 1-to-N demux
package demux_pkg;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_N_OUT = 2;
  localparam int DEF_SEL_W = $clog2(DEF_N_OUT);
  localparam int DEF_CNT_W = 8;
  typedef logic [DEF_SEL_W-1:0] lane_idx_t;
endpackage

// File: rtl/demux_lane_slot.sv
// demux_lane_slot: one-entry holding register with valid bit for a single output lane
module demux_lane_slot
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fill,
  input  logic [WIDTH-1:0] fill_data,
  input  logic             drain,
  output logic [WIDTH-1:0] data,
  output logic             valid
);
  always_ff @(posedge clk) begin
    if (reset) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      if (fill) data <= fill_data;
      valid <= fill | (valid & ~drain);
    end
  end
endmodule

// File: rtl/demux_1_to_n_reg.sv
// demux_1_to_n_reg: registered 1-to-N demux with per-lane valid/ready slots and bad-select counter
module demux_1_to_n_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_OUT = DEF_N_OUT,
  parameter int SEL_W = DEF_SEL_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic [N_OUT-1:0]       out_valid,
  input  logic [N_OUT-1:0]       out_ready,
  output logic                   err_sel,
  output logic [CNT_W-1:0]       err_count
);
  logic [N_OUT-1:0] hit, fill, drain;
  logic in_range;
  assign in_range = |hit;
  // out-of-range selects are always accepted so a bad producer cannot stall the bus
  assign in_ready = in_range ? |(hit & (~out_valid | out_ready)) : 1'b1;
  assign fill     = hit & {N_OUT{in_valid & in_ready}};
  assign drain    = out_valid & out_ready;
  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    assign hit[k] = 32'(in_sel) == k;
    demux_lane_slot #(.WIDTH(WIDTH)) u_slot (
      .clk(clk),
      .reset(reset),
      .fill(fill[k]),
      .fill_data(in_data),
      .drain(drain[k]),
      .data(out_data[k*WIDTH +: WIDTH]),
      .valid(out_valid[k])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      err_sel   <= 1'b0;
      err_count <= '0;
    end else begin
      err_sel <= in_valid & ~in_range;
      if (in_valid && !in_range && !(&err_count)) err_count <= err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_demux_1_to_n_reg.sv
// tb_demux_1_to_n_reg: directed and randomized checks of the registered 1-to-N demux
module tb_demux_1_to_n_reg;
  logic clk = 0;
  logic reset = 1;
  logic [3:0] in_data = 0;
  logic [0:0] in_sel = 0;
  logic in_valid = 0, in_ready;
  logic [7:0] out_data;
  logic [1:0] out_valid, out_ready = 0;
  logic err_sel;
  logic [7:0] err_count;
  logic [3:0] in_data3 = 0;
  logic [1:0] in_sel3 = 0;
  logic in_valid3 = 0, in_ready3;
  logic [11:0] out_data3;
  logic [2:0] out_valid3, out_ready3 = 0;
  logic err_sel3;
  logic [7:0] err_count3;
  int n_cmp = 0, n_bad = 0, drained = 0;
  bit chk_en = 0;
  int cnt [2];
  logic [3:0] front [2];
  always #5 clk = ~clk;
  demux_1_to_n_reg #(.WIDTH(4), .N_OUT(2), .SEL_W(1), .CNT_W(8)) dut2 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_sel(err_sel), .err_count(err_count)
  );
  demux_1_to_n_reg #(.WIDTH(4), .N_OUT(3), .SEL_W(2), .CNT_W(8)) dut3 (
    .clk(clk), .reset(reset), .in_data(in_data3), .in_sel(in_sel3), .in_valid(in_valid3),
    .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
    .err_sel(err_sel3), .err_count(err_count3)
  );
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic bit exp_ready();
    return cnt[in_sel] == 0 || out_ready[in_sel];
  endfunction
  // reference: each lane is a FIFO of depth one; the register shows the last word put in
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        cnt[k] = 0;
        front[k] = 0;
      end
    end else begin
      bit acc;
      acc = in_valid && exp_ready();
      for (int k = 0; k < 2; k++)
        if (cnt[k] > 0 && out_ready[k]) begin
          cnt[k]--;
          drained++;
        end
      if (acc) begin
        cnt[in_sel]++;
        front[in_sel] = in_data;
      end
    end
  end
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_valid", 32'(out_valid), 32'({cnt[1] > 0, cnt[0] > 0}));
      check("out_data", 32'(out_data), 32'({front[1], front[0]}));
      check("in_ready", 32'(in_ready), 32'(exp_ready()));
      check("err_sel", 32'(err_sel), 0);
      check("err_count", 32'(err_count), 0);
      if (cnt[0] > 1 || cnt[1] > 1) check("lane_depth", 32'(cnt[0] + cnt[1]), 2);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tick();
    tick();
    chk_en = 1;
    reset = 0;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_errcnt", 32'(err_count), 0);
    in_data = 4'd8; in_sel = 0; in_valid = 1; out_ready = 0;
    tick();
    in_valid = 0;
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_data", 32'(out_data), 32'h08);
    in_data = 4'd7; in_sel = 1; in_valid = 1;
    #1 check("t2_ready_l1", 32'(in_ready), 1);
    tick();
    in_valid = 0;
    check("t2_valid", 32'(out_valid), 32'h3);
    check("t2_data", 32'(out_data), 32'h78);
    in_data = 4'd5; in_sel = 0; in_valid = 1;
    #1 check("t2_stall", 32'(in_ready), 0);
    tick();
    check("t2_hold", 32'(out_data), 32'h78);
    out_ready = 2'b01;
    #1 check("t2_ready_drain", 32'(in_ready), 1);
    tick();
    in_valid = 0; out_ready = 0;
    check("t2_refill", 32'(out_data), 32'h75);
    check("t2_valid2", 32'(out_valid), 32'h3);
    out_ready = 2'b01;
    for (int w = 1; w <= 3; w++) begin
      in_data = 4'(w); in_sel = 0; in_valid = 1;
      tick();
      check("t3_data", 32'(out_data[3:0]), 32'(w));
      check("t3_valid", 32'(out_valid), 32'h3);
    end
    in_valid = 0; out_ready = 0;
    in_data = 4'd9; in_sel = 1; in_valid = 1; out_ready = 2'b11; reset = 1;
    tick();
    reset = 0; in_valid = 0; out_ready = 0;
    check("t4_valid", 32'(out_valid), 0);
    check("t4_data", 32'(out_data), 0);
    check("t4_errcnt", 32'(err_count), 0);
    in_sel3 = 2'd3; in_data3 = 4'hc; in_valid3 = 1;
    #1 check("t5_ready", 32'(in_ready3), 1);
    tick();
    in_valid3 = 0;
    check("t5_errsel", 32'(err_sel3), 1);
    check("t5_errcnt", 32'(err_count3), 1);
    check("t5_lanes", 32'(out_valid3), 0);
    check("t5_ldata", 32'(out_data3), 0);
    tick();
    check("t5_pulse", 32'(err_sel3), 0);
    check("t5_errcnt2", 32'(err_count3), 1);
    in_valid3 = 1;
    repeat (259) tick();
    in_valid3 = 0;
    check("t5_sat", 32'(err_count3), 255);
    tick();
    check("t5_sat_hold", 32'(err_count3), 255);
    in_sel3 = 2'd2; in_data3 = 4'ha; in_valid3 = 1;
    tick();
    in_valid3 = 0;
    check("t5_lane2_valid", 32'(out_valid3), 32'h4);
    check("t5_lane2_data", 32'(out_data3), 32'ha00);
    check("t5_lane2_noerr", 32'(err_sel3), 0);
    for (int i = 0; i < 2000; i++) begin
      reset = ($urandom_range(199) == 0);
      in_valid = 1'($urandom_range(1));
      in_sel = 1'($urandom_range(1));
      in_data = 4'($urandom);
      out_ready = 2'($urandom);
      tick();
    end
    reset = 0; in_valid = 0; out_ready = 2'b11;
    tick();
    tick();
    check("traffic", 32'(drained > 200), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
